// File: rtl/window_3x3_generator.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : window_3x3_generator
// Description : 3x3 sliding pixel window built from the current pixel and two
//               row-buffer taps, with row/column tracking and window pulses.
//               Optional left-border zeroing: define WINDOW_BORDER_ZERO_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module window_3x3_generator #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset_data,
    input  logic                    pixel_valid,
    input  logic [DATA_WIDTH-1:0]   pixel_in,
    input  logic [DATA_WIDTH-1:0]   row1_in,
    input  logic [DATA_WIDTH-1:0]   row2_in,
    input  logic [2:0]              configuration,
    output logic [9*DATA_WIDTH-1:0] window_out,
    output logic                    window_valid,
    output logic                    line_end,
    output logic                    no_config
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_FILL = 2'd1;
    localparam logic [1:0] c_ST_RUN  = 2'd2;
    localparam int         c_WIN_W   = 9 * DATA_WIDTH;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [9:0]            r_width;
    logic [9:0]            r_col;
    logic [1:0]            r_row;
    logic [c_WIN_W-1:0]    r_taps;
    logic [c_WIN_W-1:0]    r_window;
    logic                  r_window_valid;
    logic                  r_line_end;

    logic                  w_accept;
    logic                  w_col_last;
    logic                  w_cfg_load;
    logic [3:0]            w_cfg_shift;
    logic [9:0]            w_cfg_width;
    logic                  w_zero_c0;
    logic                  w_zero_c1;
    logic                  w_win_valid;
    logic [c_WIN_W-1:0]    w_taps_next;
    logic [c_WIN_W-1:0]    w_window_next;
    logic [DATA_WIDTH-1:0] w_row_src [3];

    assign w_accept    = pixel_valid && (r_state != c_ST_IDLE);
    assign w_col_last  = (r_col == (r_width - 10'd1));
    assign w_cfg_load  = (r_state == c_ST_IDLE) && (configuration != 3'd0);
    // Code n selects a row width of 2^(n+2); widened so codes 6 and 7 do not wrap.
    assign w_cfg_shift = {1'b0, configuration} + 4'd2;
    assign w_cfg_width = 10'd1 << w_cfg_shift;

`ifdef WINDOW_BORDER_ZERO_EN
    assign w_zero_c0   = (r_col < 10'd2);
    assign w_zero_c1   = (r_col == 10'd0);
    assign w_win_valid = w_accept && (r_state == c_ST_RUN);
`else
    assign w_zero_c0   = 1'b0;
    assign w_zero_c1   = 1'b0;
    assign w_win_valid = w_accept && (r_state == c_ST_RUN) && (r_col >= 10'd2);
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (configuration != 3'd0) begin
                    w_state_next = c_ST_FILL;
                end
            end
            c_ST_FILL: begin
                if (w_accept && w_col_last && (r_row == 2'd1)) begin
                    w_state_next = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                w_state_next = c_ST_RUN;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_data) begin
        if (reset_data) begin
            r_state <= c_ST_IDLE;
            r_width <= 10'd0;
            r_col   <= 10'd0;
            r_row   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            if (w_cfg_load) begin
                r_width <= w_cfg_width;
            end
            if (w_accept) begin
                if (w_col_last) begin
                    r_col <= 10'd0;
                    if (r_row != 2'd2) begin
                        r_row <= r_row + 2'd1;
                    end
                end else begin
                    r_col <= r_col + 10'd1;
                end
            end
        end
    end

    assign w_row_src[0] = row2_in;
    assign w_row_src[1] = row1_in;
    assign w_row_src[2] = pixel_in;

    // Raw taps keep shifting untouched; border zeroing only masks the output copy,
    // so stale columns still move through the window exactly as they arrived.
    generate
        for (genvar gr = 0; gr < 3; gr++) begin : g_row
            localparam int c_BASE = DATA_WIDTH * 3 * gr;

            assign w_taps_next[c_BASE +: DATA_WIDTH] =
                r_taps[c_BASE + DATA_WIDTH +: DATA_WIDTH];
            assign w_taps_next[c_BASE + DATA_WIDTH +: DATA_WIDTH] =
                r_taps[c_BASE + 2*DATA_WIDTH +: DATA_WIDTH];
            assign w_taps_next[c_BASE + 2*DATA_WIDTH +: DATA_WIDTH] = w_row_src[gr];

            assign w_window_next[c_BASE +: DATA_WIDTH] = w_zero_c0 ?
                {DATA_WIDTH{1'b0}} : w_taps_next[c_BASE +: DATA_WIDTH];
            assign w_window_next[c_BASE + DATA_WIDTH +: DATA_WIDTH] = w_zero_c1 ?
                {DATA_WIDTH{1'b0}} : w_taps_next[c_BASE + DATA_WIDTH +: DATA_WIDTH];
            assign w_window_next[c_BASE + 2*DATA_WIDTH +: DATA_WIDTH] =
                w_taps_next[c_BASE + 2*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset_data) begin
        if (reset_data) begin
            r_taps         <= '0;
            r_window       <= '0;
            r_window_valid <= 1'b0;
            r_line_end     <= 1'b0;
        end else begin
            r_window_valid <= w_win_valid;
            r_line_end     <= w_accept && w_col_last;
            if (w_accept) begin
                r_taps   <= w_taps_next;
                r_window <= w_window_next;
            end
        end
    end

    assign window_out   = r_window;
    assign window_valid = r_window_valid;
    assign line_end     = r_line_end;
    assign no_config    = (r_state == c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_window_3x3_generator.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_window_3x3_generator
// Description : Directed self-checking bench for window_3x3_generator (width 8).
//               Expectations follow WINDOW_BORDER_ZERO_EN when it is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_window_3x3_generator;

    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset_data;
    logic            pixel_valid;
    logic [DW-1:0]   pixel_in;
    logic [DW-1:0]   row1_in;
    logic [DW-1:0]   row2_in;
    logic [2:0]      configuration;
    logic [9*DW-1:0] window_out;
    logic            window_valid;
    logic            line_end;
    logic            no_config;

    int              checks = 0;
    int              errors = 0;
    int              n_le;
    int              n_wv;
    logic [9*DW-1:0] last_exp;

    window_3x3_generator #(.DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .reset_data    (reset_data),
        .pixel_valid   (pixel_valid),
        .pixel_in      (pixel_in),
        .row1_in       (row1_in),
        .row2_in       (row2_in),
        .configuration (configuration),
        .window_out    (window_out),
        .window_valid  (window_valid),
        .line_end      (line_end),
        .no_config     (no_config)
    );

    always #5 clk = ~clk;

    // Pixel value of image row/col in the 8-wide test image; rows before the image are 0.
    function automatic int val(input int row, input int col);
        return (row < 0) ? 0 : row * 8 + col + 1;
    endfunction

    // Window after accepting stream pixel k: tap c holds the pixel k-2+c of its row source.
    function automatic logic [9*DW-1:0] model(input int k);
        logic [9*DW-1:0] m;
        int j;
        m = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                j = k - 2 + c;
                if (j >= 0) m[DW*(3*r+c) +: DW] = DW'(val(j/8 - (2-r), j%8));
`ifdef WINDOW_BORDER_ZERO_EN
                if (((k%8) == 0 && c < 2) || ((k%8) == 1 && c == 0)) m[DW*(3*r+c) +: DW] = '0;
`endif
            end
        end
        return m;
    endfunction

    function automatic logic exp_valid(input int k);
`ifdef WINDOW_BORDER_ZERO_EN
        return (k / 8) >= 2;
`else
        return ((k / 8) >= 2) && ((k % 8) >= 2);
`endif
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_data    = 1'b1;
        pixel_valid   = 1'b0;
        configuration = 3'd0;
        @(negedge clk);
        reset_data    = 1'b0;
    endtask

    task automatic configure(input logic [2:0] cfg);
        @(negedge clk);
        pixel_valid   = 1'b0;
        configuration = cfg;
        @(posedge clk);
        #1;
        chk("no_config_after_cfg", no_config, 1'b0);
    endtask

    task automatic stream(input int k0, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int k;
            k = k0 + i;
            @(negedge clk);
            pixel_valid = 1'b1;
            pixel_in    = DW'(val(k/8, k%8));
            row1_in     = DW'(val(k/8 - 1, k%8));
            row2_in     = DW'(val(k/8 - 2, k%8));
            @(posedge clk);
            #1;
            last_exp = model(k);
            chk("line_end", line_end, ((k % 8) == 7));
            chk("window_valid", window_valid, exp_valid(k));
            chk("window_out", window_out, last_exp);
            if (line_end) n_le++;
            if (window_valid) n_wv++;
`ifdef WINDOW_BORDER_ZERO_EN
            if (k == 16) begin
                chk("first_row2_taps", window_out[6*DW +: 3*DW], 24'h110000);
                chk("first_row1_taps", window_out[3*DW +: 3*DW], 24'h090000);
            end
`else
            if (k == 18) begin
                chk("first_row2_taps", window_out[6*DW +: 3*DW], 24'h131211);
                chk("first_row1_taps", window_out[3*DW +: 3*DW], 24'h0B0A09);
            end
`endif
            if (gaps) begin
                @(negedge clk);
                pixel_valid = 1'b0;
                pixel_in    = 8'hAA;
                row1_in     = 8'h55;
                row2_in     = 8'hFF;
                @(posedge clk);
                #1;
                chk("gap_window_valid", window_valid, 1'b0);
                chk("gap_line_end", line_end, 1'b0);
                chk("gap_hold", window_out, last_exp);
            end
        end
        @(negedge clk);
        pixel_valid = 1'b0;
    endtask

    initial begin
        reset_data    = 1'b1;
        pixel_valid   = 1'b0;
        pixel_in      = '0;
        row1_in       = '0;
        row2_in       = '0;
        configuration = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_window_out", window_out, '0);
        chk("reset_window_valid", window_valid, 1'b0);
        chk("reset_line_end", line_end, 1'b0);
        chk("reset_no_config", no_config, 1'b1);
        @(negedge clk);
        reset_data = 1'b0;

        // Unconfigured: valid pixels must be ignored.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pixel_valid = 1'b1;
            pixel_in    = DW'(i + 1);
            row1_in     = DW'(i + 9);
            row2_in     = DW'(i + 17);
            @(posedge clk);
            #1;
            chk("idle_no_config", no_config, 1'b1);
            chk("idle_window_valid", window_valid, 1'b0);
            chk("idle_line_end", line_end, 1'b0);
            chk("idle_window_out", window_out, '0);
        end

        // Contiguous 24-pixel stream at width 8.
        configure(3'd1);
        n_le = 0;
        n_wv = 0;
        stream(0, 24, 1'b0);
        chk("line_end_count", n_le, 3);
`ifdef WINDOW_BORDER_ZERO_EN
        chk("window_valid_count", n_wv, 8);
`else
        chk("window_valid_count", n_wv, 6);
`endif

        // Same stream with idle gaps between pixels.
        do_reset();
        configure(3'd1);
        n_le = 0;
        n_wv = 0;
        stream(0, 24, 1'b1);
        chk("gap_line_end_count", n_le, 3);
`ifdef WINDOW_BORDER_ZERO_EN
        chk("gap_window_valid_count", n_wv, 8);
`else
        chk("gap_window_valid_count", n_wv, 6);
`endif

        // Configuration change while running must not alter the width.
        @(negedge clk);
        configuration = 3'd2;
        n_le = 0;
        stream(24, 16, 1'b0);
        chk("cfg_change_line_end_count", n_le, 2);
        chk("cfg_change_no_config", no_config, 1'b0);

        // Reset asserted mid-row at column 4 of row 2.
        do_reset();
        configure(3'd1);
        stream(0, 20, 1'b0);
        @(negedge clk);
        pixel_valid = 1'b1;
        pixel_in    = DW'(val(2, 4));
        row1_in     = DW'(val(1, 4));
        row2_in     = DW'(val(0, 4));
        #2;
        reset_data = 1'b1;
        #1;
        chk("midrow_reset_window_out", window_out, '0);
        chk("midrow_reset_window_valid", window_valid, 1'b0);
        chk("midrow_reset_line_end", line_end, 1'b0);
        chk("midrow_reset_no_config", no_config, 1'b1);
        @(negedge clk);
        reset_data    = 1'b0;
        pixel_valid   = 1'b0;
        configuration = 3'd0;
        @(posedge clk);
        #1;
        chk("after_reset_still_idle", no_config, 1'b1);
        configure(3'd1);
        n_le = 0;
        n_wv = 0;
        stream(0, 8, 1'b0);
        chk("restart_line_end_count", n_le, 1);
        chk("restart_window_valid_count", n_wv, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
